sysbus: RTL and testbench

System bus stage directly downstream of the CPU core. It consumes the core's single memory port (`address`, `data_out`, `data_rw`) and returns `data_in`. It decodes each access to either the external word RAM or a small MMIO space. The MMIO space holds a transmit byte FIFO with a valid/ready output and a free-running cycle counter.

---
 rtl/sysbus_if.sv | 34 +++
 rtl/sysbus.sv | 146 ++++++++++++++
 tb/tb_sysbus.sv | 345 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sysbus_if.sv
// sysbus_if: bundles the three buses around the system bus stage.
//   CPU side : cpu_address, cpu_data_out, cpu_data_rw (to stage), cpu_data_in (from stage)
//   RAM side : ram_addr, ram_wdata, ram_we (from stage), ram_rdata (to stage)
//   TX side  : tx_data, tx_valid (from stage), tx_ready (to stage)
// Modports:
//   slave  - the sysbus stage itself
//   master - the surrounding system (core, RAM, byte consumer)
interface sysbus_if #(
    parameter int RAM_AW = 14
);
    logic [31:0]       cpu_address;
    logic [31:0]       cpu_data_out;
    logic              cpu_data_rw;
    logic [31:0]       cpu_data_in;

    logic [RAM_AW-1:0] ram_addr;
    logic [31:0]       ram_wdata;
    logic              ram_we;
    logic [31:0]       ram_rdata;

    logic [7:0]        tx_data;
    logic              tx_valid;
    logic              tx_ready;

    modport slave (
        input  cpu_address, cpu_data_out, cpu_data_rw, ram_rdata, tx_ready,
        output cpu_data_in, ram_addr, ram_wdata, ram_we, tx_data, tx_valid
    );

    modport master (
        output cpu_address, cpu_data_out, cpu_data_rw, ram_rdata, tx_ready,
        input  cpu_data_in, ram_addr, ram_wdata, ram_we, tx_data, tx_valid
    );
endinterface

// File: rtl/sysbus.sv
// sysbus: system bus stage behind the CPU core's single memory port.
// Decodes each access to the external word RAM (address[31:28] == 0x0) or the
// MMIO block (address[31:28] == 0xF); every other region reads 0 and drops
// writes. MMIO registers, selected by address[3:2]:
//   0 TXDATA : write pushes data[7:0] into the TX FIFO, reads 0
//   1 STATUS : read {count[8:4], overflow[2], empty[1], full[0]}, write clears overflow
//   2 CYCLE  : free-running cycle counter, write zeroes it
//   3        : reserved, reads 0
// Optional feature: define SYSBUS_CYCLE_COUNTER_EN to build the CYCLE counter;
// without it CYCLE reads 0 and ignores writes.
// Ports:
//   clk    - single clock, rising edge
//   reset  - synchronous, active-high
//   bus    - sysbus_if.slave (CPU, RAM and TX handshake signals)
module sysbus #(
    parameter int RAM_AW     = 14,
    parameter int FIFO_DEPTH = 8
) (
    input  logic     clk,
    input  logic     reset,
    sysbus_if.slave  bus
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    // ---------------------------------------------------------------- decode
    logic [3:0] region;
    logic [1:0] reg_sel;
    logic       ram_sel;
    logic       mmio_sel;
    logic       wr;

    assign region   = bus.cpu_address[31:28];
    assign reg_sel  = bus.cpu_address[3:2];
    assign ram_sel  = (region == 4'h0);
    assign mmio_sel = (region == 4'hF);
    // Stores coincident with reset are dropped everywhere.
    assign wr       = bus.cpu_data_rw & ~reset;

    logic push_req;
    logic stat_wr;

    assign push_req = wr & mmio_sel & (reg_sel == 2'd0);
    assign stat_wr  = wr & mmio_sel & (reg_sel == 2'd1);

    // Only some address bits feed logic; the rest are intentionally ignored.
    logic unused_addr;
    assign unused_addr = ^bus.cpu_address;

    // ------------------------------------------------------------------- RAM
    // Upper address bits are dropped, so the RAM aliases across its region.
    assign bus.ram_addr  = bus.cpu_address[RAM_AW+1:2];
    assign bus.ram_wdata = bus.cpu_data_out;
    assign bus.ram_we    = wr & ram_sel;

    // --------------------------------------------------------------- TX FIFO
    logic [7:0]    fifo_mem [FIFO_DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic          overflow;

    logic full;
    logic empty;
    logic pop;
    logic push;
    logic ovf_set;

    assign full  = (count == CW'(FIFO_DEPTH));
    assign empty = (count == '0);
    assign pop   = ~empty & bus.tx_ready;
    // A pop in the same cycle frees the slot, so a push into a full FIFO is
    // still accepted when the consumer is draining.
    assign push    = push_req & (~full | pop);
    assign ovf_set = push_req & full & ~pop;

    // Power-of-two depth: pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage is not reset; tx_data shows whatever entry 0 holds after reset.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= bus.cpu_data_out[7:0];
    end

    // Set has priority over a same-cycle STATUS write.
    always_ff @(posedge clk) begin
        if (reset)        overflow <= 1'b0;
        else if (ovf_set) overflow <= 1'b1;
        else if (stat_wr) overflow <= 1'b0;
    end

    assign bus.tx_data  = fifo_mem[rd_ptr];
    assign bus.tx_valid = ~empty;

    logic [31:0] status;
    assign status = {23'd0, 5'(count), 1'b0, overflow, empty, full};

    // --------------------------------------------------------- cycle counter
    logic [31:0] cycle_rd;

`ifdef SYSBUS_CYCLE_COUNTER_EN
    logic [31:0] cycle_q;
    logic        cyc_wr;

    assign cyc_wr = wr & mmio_sel & (reg_sel == 2'd2);

    // A write wins over the increment; the increment wraps naturally.
    always_ff @(posedge clk) begin
        if (reset)       cycle_q <= '0;
        else if (cyc_wr) cycle_q <= '0;
        else             cycle_q <= cycle_q + 32'd1;
    end

    assign cycle_rd = cycle_q;
`else
    assign cycle_rd = 32'd0;
`endif

    // ------------------------------------------------------------- read mux
    always_comb begin
        bus.cpu_data_in = 32'd0;
        if (ram_sel) begin
            bus.cpu_data_in = bus.ram_rdata;
        end else if (mmio_sel) begin
            case (reg_sel)
                2'd1:    bus.cpu_data_in = status;
                2'd2:    bus.cpu_data_in = cycle_rd;
                default: bus.cpu_data_in = 32'd0;
            endcase
        end
    end
endmodule

// File: tb/tb_sysbus.sv
// tb_sysbus: directed self-checking bench for sysbus. Inputs change on the
// falling edge; outputs are sampled 1 ns later, away from the rising edge.
module tb_sysbus;
    localparam int RAM_AW = 14;

    localparam logic [31:0] A_TX   = 32'hF000_0000;
    localparam logic [31:0] A_STAT = 32'hF000_0004;
    localparam logic [31:0] A_CYC  = 32'hF000_0008;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    sysbus_if #(.RAM_AW(RAM_AW)) bus ();

    sysbus #(.RAM_AW(RAM_AW), .FIFO_DEPTH(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Word RAM model: combinational read, written on the rising edge.
    logic [31:0] ram_mem [2**RAM_AW];
    assign bus.ram_rdata = ram_mem[bus.ram_addr];
    always @(posedge clk) begin
        if (bus.ram_we) ram_mem[bus.ram_addr] <= bus.ram_wdata;
    end

    // One-cycle store; returns at the falling edge after the store's edge.
    task automatic cpu_write(input logic [31:0] addr, input logic [31:0] data);
        @(negedge clk);
        bus.cpu_address  = addr;
        bus.cpu_data_out = data;
        bus.cpu_data_rw  = 1'b1;
        @(negedge clk);
        bus.cpu_data_rw  = 1'b0;
    endtask

    task automatic cpu_read(input logic [31:0] addr, output logic [31:0] data);
        @(negedge clk);
        bus.cpu_address = addr;
        bus.cpu_data_rw = 1'b0;
        #1 data = bus.cpu_data_in;
    endtask

    task automatic test_reset;
        logic [31:0] d;
        reset = 1'b1;
        bus.cpu_address  = 32'h0000_0000;
        bus.cpu_data_out = 32'hDEAD_BEEF;
        bus.cpu_data_rw  = 1'b1;
        bus.tx_ready     = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (bus.ram_we !== 1'b0) begin
            errors++; $display("FAIL reset_ram_we got %0b want 0", bus.ram_we);
        end
        checks++;
        if (bus.tx_valid !== 1'b0) begin
            errors++; $display("FAIL reset_tx_valid got %0b want 0", bus.tx_valid);
        end
        // A TXDATA store under reset must not land in the FIFO.
        bus.cpu_address = A_TX;
        @(negedge clk);
        bus.cpu_data_rw = 1'b0;
        bus.cpu_address = A_STAT;
        #1;
        checks++;
        if (bus.cpu_data_in !== 32'h02) begin
            errors++; $display("FAIL reset_status got %h want 00000002", bus.cpu_data_in);
        end
        reset = 1'b0;
        cpu_read(A_STAT, d);
        checks++;
        if (d !== 32'h02) begin
            errors++; $display("FAIL post_reset_status got %h want 00000002", d);
        end
    endtask

    task automatic test_ram;
        logic [31:0] d;
        @(negedge clk);
        bus.cpu_address  = 32'h0000_0010;
        bus.cpu_data_out = 32'h1234_5678;
        bus.cpu_data_rw  = 1'b1;
        #1;
        checks++;
        if (bus.ram_we !== 1'b1 || bus.ram_addr !== 14'd4 || bus.ram_wdata !== 32'h1234_5678) begin
            errors++;
            $display("FAIL ram_store we=%0b addr=%0d wdata=%h want we=1 addr=4 wdata=12345678",
                     bus.ram_we, bus.ram_addr, bus.ram_wdata);
        end
        @(negedge clk);
        bus.cpu_data_rw = 1'b0;
        #1;
        checks++;
        if (bus.ram_we !== 1'b0) begin
            errors++; $display("FAIL ram_we_one_cycle got %0b want 0", bus.ram_we);
        end
        cpu_read(32'h0000_0010, d);
        checks++;
        if (d !== 32'h1234_5678) begin
            errors++; $display("FAIL ram_load got %h want 12345678", d);
        end
        // Byte offset ignored, upper bits alias onto word 4.
        cpu_write(32'h0001_0013, 32'hCAFE_0001);
        cpu_read(32'h0000_0011, d);
        checks++;
        if (d !== 32'hCAFE_0001) begin
            errors++; $display("FAIL ram_alias got %h want cafe0001", d);
        end
        cpu_write(32'h0000_0000, 32'hA5A5_A5A5);
    endtask

    task automatic test_fifo_basic;
        logic [31:0] d;
        // Push into an empty FIFO: no same-cycle bypass.
        @(negedge clk);
        bus.cpu_address  = A_TX;
        bus.cpu_data_out = 32'hFFFF_FF41;
        bus.cpu_data_rw  = 1'b1;
        #1;
        checks++;
        if (bus.tx_valid !== 1'b0) begin
            errors++; $display("FAIL push_no_bypass got %0b want 0", bus.tx_valid);
        end
        @(negedge clk);
        bus.cpu_data_rw = 1'b0;
        #1;
        checks++;
        if (bus.tx_valid !== 1'b1 || bus.tx_data !== 8'h41) begin
            errors++; $display("FAIL push_valid valid=%0b data=%h want 1 41", bus.tx_valid, bus.tx_data);
        end
        cpu_write(A_TX, 32'h42);
        cpu_write(A_TX, 32'h43);
        cpu_read(A_STAT, d);
        checks++;
        if (d !== 32'h30) begin
            errors++; $display("FAIL status_three got %h want 00000030", d);
        end
        cpu_read(A_TX, d);
        checks++;
        if (d !== 32'h0) begin
            errors++; $display("FAIL txdata_read got %h want 0", d);
        end
        bus.tx_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (bus.tx_valid !== 1'b1 || bus.tx_data !== 8'(8'h41 + i)) begin
                errors++;
                $display("FAIL drain_%0d valid=%0b data=%h want 1 %h", i, bus.tx_valid, bus.tx_data, 8'(8'h41 + i));
            end
            @(negedge clk);
        end
        #1;
        checks++;
        if (bus.tx_valid !== 1'b0) begin
            errors++; $display("FAIL drain_empty got %0b want 0", bus.tx_valid);
        end
        bus.tx_ready = 1'b0;
        cpu_read(A_STAT, d);
        checks++;
        if (d !== 32'h02) begin
            errors++; $display("FAIL status_drained got %h want 00000002", d);
        end
    endtask

    task automatic test_overflow;
        logic [31:0] d;
        for (int i = 0; i < 8; i++) cpu_write(A_TX, 32'h10 + i);
        cpu_read(A_STAT, d);
        checks++;
        if (d !== 32'h81) begin
            errors++; $display("FAIL status_full got %h want 00000081", d);
        end
        cpu_write(A_TX, 32'h99);
        cpu_read(A_STAT, d);
        checks++;
        if (d !== 32'h85) begin
            errors++; $display("FAIL status_overflow got %h want 00000085", d);
        end
        cpu_write(A_STAT, 32'h0);
        cpu_read(A_STAT, d);
        checks++;
        if (d !== 32'h81) begin
            errors++; $display("FAIL status_ovf_clear got %h want 00000081", d);
        end
        // The dropped 0x99 must not appear.
        @(negedge clk);
        bus.tx_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1;
            checks++;
            if (bus.tx_data !== 8'(8'h10 + i)) begin
                errors++; $display("FAIL ovf_drain_%0d got %h want %h", i, bus.tx_data, 8'(8'h10 + i));
            end
            @(negedge clk);
        end
        bus.tx_ready = 1'b0;
    endtask

    task automatic test_full_push_pop;
        logic [31:0] d;
        for (int i = 0; i < 8; i++) cpu_write(A_TX, 32'h60 + i);
        @(negedge clk);
        bus.cpu_address  = A_TX;
        bus.cpu_data_out = 32'h55;
        bus.cpu_data_rw  = 1'b1;
        bus.tx_ready     = 1'b1;
        @(negedge clk);
        bus.cpu_data_rw  = 1'b0;
        bus.tx_ready     = 1'b0;
        cpu_read(A_STAT, d);
        checks++;
        if (d !== 32'h81) begin
            errors++; $display("FAIL full_push_pop_status got %h want 00000081", d);
        end
        bus.tx_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1;
            checks++;
            if (bus.tx_data !== ((i == 7) ? 8'h55 : 8'(8'h61 + i))) begin
                errors++;
                $display("FAIL wrap_drain_%0d got %h want %h", i, bus.tx_data, (i == 7) ? 8'h55 : 8'(8'h61 + i));
            end
            @(negedge clk);
        end
        #1;
        checks++;
        if (bus.tx_valid !== 1'b0) begin
            errors++; $display("FAIL wrap_drain_empty got %0b want 0", bus.tx_valid);
        end
        bus.tx_ready = 1'b0;
    endtask

    task automatic test_cycle;
        logic [31:0] d;
        cpu_write(A_CYC, 32'h1234);
        repeat (4) @(negedge clk);
        cpu_read(A_CYC, d);
`ifdef SYSBUS_CYCLE_COUNTER_EN
        checks++;
        if (d !== 32'd5) begin
            errors++; $display("FAIL cycle_count got %0d want 5", d);
        end
        @(negedge clk);
        force dut.cycle_q = 32'hFFFF_FFFF;
        #1;
        checks++;
        if (bus.cpu_data_in !== 32'hFFFF_FFFF) begin
            errors++; $display("FAIL cycle_preload got %h want ffffffff", bus.cpu_data_in);
        end
        release dut.cycle_q;
        @(negedge clk);
        #1;
        checks++;
        if (bus.cpu_data_in !== 32'h0) begin
            errors++; $display("FAIL cycle_wrap got %h want 0", bus.cpu_data_in);
        end
`else
        checks++;
        if (d !== 32'd0) begin
            errors++; $display("FAIL cycle_absent got %h want 0", d);
        end
`endif
    endtask

    task automatic test_unmapped;
        logic [31:0] d;
        cpu_read(32'h8000_0000, d);
        checks++;
        if (d !== 32'h0) begin
            errors++; $display("FAIL unmapped_read got %h want 0", d);
        end
        cpu_read(32'hF000_000C, d);
        checks++;
        if (d !== 32'h0) begin
            errors++; $display("FAIL mmio3_read got %h want 0", d);
        end
        @(negedge clk);
        bus.cpu_address  = 32'h8000_0000;
        bus.cpu_data_out = 32'h77;
        bus.cpu_data_rw  = 1'b1;
        #1;
        checks++;
        if (bus.ram_we !== 1'b0) begin
            errors++; $display("FAIL unmapped_ram_we got %0b want 0", bus.ram_we);
        end
        @(negedge clk);
        bus.cpu_data_rw = 1'b0;
        cpu_read(A_STAT, d);
        checks++;
        if (d !== 32'h02 || bus.tx_valid !== 1'b0) begin
            errors++; $display("FAIL unmapped_fifo status=%h valid=%0b want 00000002 0", d, bus.tx_valid);
        end
        cpu_read(32'h0000_0000, d);
        checks++;
        if (d !== 32'hA5A5_A5A5) begin
            errors++; $display("FAIL unmapped_ram_intact got %h want a5a5a5a5", d);
        end
    endtask

    task automatic test_reset_mid_drain;
        logic [31:0] d;
        for (int i = 0; i < 3; i++) cpu_write(A_TX, 32'h30 + i);
        bus.tx_ready = 1'b1;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        bus.tx_ready = 1'b0;
        #1;
        checks++;
        if (bus.tx_valid !== 1'b0) begin
            errors++; $display("FAIL mid_drain_reset_valid got %0b want 0", bus.tx_valid);
        end
        cpu_read(A_STAT, d);
        checks++;
        if (d !== 32'h02) begin
            errors++; $display("FAIL mid_drain_reset_status got %h want 00000002", d);
        end
    endtask

    initial begin
        bus.cpu_address  = 32'h0;
        bus.cpu_data_out = 32'h0;
        bus.cpu_data_rw  = 1'b0;
        bus.tx_ready     = 1'b0;
        test_reset();
        test_ram();
        test_fifo_basic();
        test_overflow();
        test_full_push_pop();
        test_cycle();
        test_unmapped();
        test_reset_mid_drain();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
